sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 215 +++++++++++++++++++++
 tb/tb_sdram_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// ============================================================================
// sdram_responder : single-clock SDRAM device model (banks, CL pipe, init FSM).
// Macro SDRAM_RESPONDER_CHECK_EN enables protocol violation detection. Rev 1.0
// ============================================================================
`default_nettype none

module sdram_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WIDTH  = 13,
  parameter int MEM_AW     = 12,
  parameter int T_RCD      = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    SDRAM_nCS,
  input  logic                    SDRAM_nRAS,
  input  logic                    SDRAM_nCAS,
  input  logic                    SDRAM_nWE,
  input  logic [ROW_WIDTH-1:0]    SDRAM_A,
  input  logic [1:0]              SDRAM_BA,
  input  logic [DATA_WIDTH/8-1:0] SDRAM_DQM,
  input  logic [DATA_WIDTH-1:0]   dq_in,
  output logic [DATA_WIDTH-1:0]   dq_out,
  output logic [DATA_WIDTH/8-1:0] dq_oe,
  output logic                    init_done,
  output logic [15:0]             refresh_cnt,
  output logic                    err,
  output logic [2:0]              err_code
);

  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_MRS, CMD_ACT, CMD_WR, CMD_RD, CMD_REF, CMD_PRE
  } cmd_t;

  typedef enum logic [2:0] {
    S_WAIT_PRE, S_WAIT_REF1, S_WAIT_REF2, S_WAIT_MRS, S_DONE
  } init_t;

  cmd_t                  w_cmd;
  init_t                 r_init;
  init_t                 w_init_nxt;
  logic [3:0]            r_bank_act;
  logic [ROW_WIDTH-1:0]  r_row [4];
  logic                  r_cl3;
  logic [MEM_AW-1:0]     w_addr;
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<MEM_AW)-1];
  logic                  r_pv0, r_pv1;
  logic [DATA_WIDTH-1:0] r_pd0, r_pd1;
  logic [LANES-1:0]      r_pm0, r_pm1;

  always_comb begin
    w_cmd = CMD_NOP;
    if (!SDRAM_nCS) begin
      case ({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE})
        3'b000:  w_cmd = CMD_MRS;
        3'b011:  w_cmd = CMD_ACT;
        3'b100:  w_cmd = CMD_WR;
        3'b101:  w_cmd = CMD_RD;
        3'b001:  w_cmd = CMD_REF;
        3'b010:  w_cmd = CMD_PRE;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  // Word address {bank, open row, column}, keeping only the low MEM_AW bits.
  assign w_addr = MEM_AW'({SDRAM_BA, r_row[SDRAM_BA], SDRAM_A[8:0]});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bank_act <= '0;
      for (int b = 0; b < 4; b++) r_row[b] <= '0;
    end else begin
      case (w_cmd)
        CMD_ACT: begin
          r_bank_act[SDRAM_BA] <= 1'b1;
          r_row[SDRAM_BA]      <= SDRAM_A;
        end
        CMD_RD, CMD_WR: if (SDRAM_A[10]) r_bank_act[SDRAM_BA] <= 1'b0;
        CMD_PRE: begin
          if (SDRAM_A[10]) r_bank_act <= '0;
          else             r_bank_act[SDRAM_BA] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cl3       <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      if (w_cmd == CMD_MRS) begin
        if (SDRAM_A[6:4] == 3'd3)      r_cl3 <= 1'b1;
        else if (SDRAM_A[6:4] == 3'd2) r_cl3 <= 1'b0;
      end
      if (w_cmd == CMD_REF && refresh_cnt != 16'hFFFF)
        refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_init <= S_WAIT_PRE;
    else         r_init <= w_init_nxt;
  end

  always_comb begin
    w_init_nxt = r_init;
    case (r_init)
      S_WAIT_PRE:  if (w_cmd == CMD_PRE && SDRAM_A[10]) w_init_nxt = S_WAIT_REF1;
      S_WAIT_REF1: if (w_cmd == CMD_REF) w_init_nxt = S_WAIT_REF2;
      S_WAIT_REF2: if (w_cmd == CMD_REF) w_init_nxt = S_WAIT_MRS;
      S_WAIT_MRS:  if (w_cmd == CMD_MRS) w_init_nxt = S_DONE;
      default:     w_init_nxt = S_DONE;
    endcase
  end

  assign init_done = (r_init == S_DONE);

  // RAM is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_cmd == CMD_WR) begin
      for (int l = 0; l < LANES; l++)
        if (!SDRAM_DQM[l]) r_mem[w_addr][l*8 +: 8] <= dq_in[l*8 +: 8];
    end
  end

  // Read pipe: stage 1 is entered only for CL=3; the output register is the last stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pv0  <= 1'b0;
      r_pv1  <= 1'b0;
      r_pd0  <= '0;
      r_pd1  <= '0;
      r_pm0  <= '0;
      r_pm1  <= '0;
      dq_out <= '0;
      dq_oe  <= '0;
    end else begin
      r_pv0 <= r_pv1;
      r_pd0 <= r_pd1;
      r_pm0 <= r_pm1;
      r_pv1 <= 1'b0;
      if (w_cmd == CMD_RD) begin
        if (r_cl3) begin
          r_pv1 <= 1'b1;
          r_pd1 <= r_mem[w_addr];
          r_pm1 <= ~SDRAM_DQM;
        end else begin
          r_pv0 <= 1'b1;
          r_pd0 <= r_mem[w_addr];
          r_pm0 <= ~SDRAM_DQM;
        end
      end
      dq_out <= r_pv0 ? r_pd0 : '0;
      dq_oe  <= r_pv0 ? r_pm0 : '0;
    end
  end

`ifdef SDRAM_RESPONDER_CHECK_EN
  localparam int CW = (T_RCD > 1) ? $clog2(T_RCD) : 1;
  localparam logic [CW-1:0] C_RCD_LOAD = CW'(T_RCD - 1);

  logic [CW-1:0] r_rcd [4];
  logic [2:0]    w_viol;
  logic          w_rw;
  logic          w_sel_act;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int b = 0; b < 4; b++) r_rcd[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - CW'(1);
      if (w_cmd == CMD_ACT) r_rcd[SDRAM_BA] <= C_RCD_LOAD;
    end
  end

  assign w_rw      = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
  assign w_sel_act = r_bank_act[SDRAM_BA];

  // Highest code tested first so the lowest simultaneous code wins.
  always_comb begin
    w_viol = 3'd0;
    if ((w_rw || w_cmd == CMD_ACT) && !init_done) w_viol = 3'd6;
    if (w_cmd == CMD_MRS && SDRAM_A[6:4] != 3'd2 && SDRAM_A[6:4] != 3'd3) w_viol = 3'd5;
    if ((w_cmd == CMD_REF || w_cmd == CMD_MRS) && (|r_bank_act)) w_viol = 3'd4;
    if (w_rw && w_sel_act && r_rcd[SDRAM_BA] != '0) w_viol = 3'd3;
    if (w_rw && !w_sel_act) w_viol = 3'd2;
    if (w_cmd == CMD_ACT && w_sel_act) w_viol = 3'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err      <= 1'b0;
      err_code <= 3'd0;
    end else if (!err && w_viol != 3'd0) begin
      err      <= 1'b1;
      err_code <= w_viol;
    end
  end
`else
  // Bank state only drives auto-precharge bookkeeping when checking is compiled out.
  logic w_unused_bank;
  assign w_unused_bank = ^r_bank_act;
  assign err           = 1'b0;
  assign err_code      = 3'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdram_responder.sv
// ============================================================================
// tb_sdram_responder : randomized self-checking bench for sdram_responder.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sdram_responder;

`ifdef SDRAM_RESPONDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [3:0] C_NOP = 4'b1111;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;

  logic        clk, resetn;
  logic        nCS, nRAS, nCAS, nWE;
  logic [12:0] A;
  logic [1:0]  BA, DQM;
  logic [15:0] dqi, dq_out;
  logic [1:0]  dq_oe;
  logic        init_done, err;
  logic [15:0] refresh_cnt;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_m [int];
  int          brow [4];

  sdram_responder dut (
    .clk(clk), .resetn(resetn),
    .SDRAM_nCS(nCS), .SDRAM_nRAS(nRAS), .SDRAM_nCAS(nCAS), .SDRAM_nWE(nWE),
    .SDRAM_A(A), .SDRAM_BA(BA), .SDRAM_DQM(DQM), .dq_in(dqi),
    .dq_out(dq_out), .dq_oe(dq_oe), .init_done(init_done),
    .refresh_cnt(refresh_cnt), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int maddr(input int ba, input int row, input int col);
    return (ba * (1 << 22) + row * 512 + col) % 4096;
  endfunction

  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [1:0] m, input logic [15:0] d);
    {nCS, nRAS, nCAS, nWE} = c;
    BA = ba; A = a; DQM = m; dqi = d;
    @(posedge clk); #1;
    {nCS, nRAS, nCAS, nWE} = C_NOP;
  endtask

  task automatic nop();
    cmd(C_NOP, 2'd0, 13'd0, 2'd0, 16'd0);
  endtask

  task automatic act(input int ba, input int row);
    brow[ba] = row;
    cmd(C_ACT, 2'(ba), 13'(row), 2'd0, 16'd0);
  endtask

  task automatic wr(input int ba, input int col, input bit ap, input logic [1:0] m,
                    input logic [15:0] d);
    int ad;
    logic [15:0] w;
    ad = maddr(ba, brow[ba], col);
    w  = mem_m.exists(ad) ? mem_m[ad] : 16'h0000;
    if (!m[0]) w[7:0]  = d[7:0];
    if (!m[1]) w[15:8] = d[15:8];
    mem_m[ad] = w;
    cmd(C_WR, 2'(ba), {2'b00, ap, 1'b0, 9'(col)}, m, d);
  endtask

  task automatic rd(input int ba, input int col, input bit ap, input logic [1:0] m);
    cmd(C_RD, 2'(ba), {2'b00, ap, 1'b0, 9'(col)}, m, 16'd0);
  endtask

  task automatic do_init(input int cl);
    cmd(C_PRE, 2'd0, 13'h400, 2'd0, 16'd0);
    cmd(C_REF, 2'd0, 13'd0, 2'd0, 16'd0);
    cmd(C_REF, 2'd0, 13'd0, 2'd0, 16'd0);
    cmd(C_MRS, 2'd0, 13'(cl << 4), 2'd0, 16'd0);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    {nCS, nRAS, nCAS, nWE} = C_NOP;
    BA = 0; A = 0; DQM = 0; dqi = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    n_checks++; if (refresh_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_refresh: got %h want 0", refresh_cnt); end
    n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL reset_oe: got %b want 00", dq_oe); end
    n_checks++; if (dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_dq: got %h want 0", dq_out); end
    n_checks++; if (err !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_code); end
    resetn = 1'b1;
    nop();
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL idle_init_done: got %b want 0", init_done); end
  endtask

  task automatic test_init();
    cmd(C_PRE, 2'd0, 13'h400, 2'd0, 16'd0);
    cmd(C_REF, 2'd0, 13'd0, 2'd0, 16'd0);
    cmd(C_REF, 2'd0, 13'd0, 2'd0, 16'd0);
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_early: got %b want 0", init_done); end
    cmd(C_MRS, 2'd0, 13'h020, 2'd0, 16'd0);
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1", init_done); end
    n_checks++; if (refresh_cnt !== 16'd2) begin n_fail++; $display("FAIL init_refresh: got %0d want 2", refresh_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL init_err: got %b want 0", err); end
  endtask

  task automatic test_write_read();
    logic [15:0] ex;
    act(0, 5); nop();
    wr(0, 3, 1'b0, 2'b00, 16'h1234);
    wr(0, 3, 1'b1, 2'b10, 16'hA55A);
    ex = mem_m[maddr(0, 5, 3)];
    act(0, 5); nop();
    rd(0, 3, 1'b0, 2'b00);
    n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL wr_rd_early_oe: got %b want 00", dq_oe); end
    nop();
    n_checks++; if (dq_oe !== 2'b11 || dq_out !== ex) begin n_fail++; $display("FAIL wr_rd_data: got %b/%h want 11/%h", dq_oe, dq_out, ex); end
    n_checks++; if (dq_out[7:0] !== 8'h5A) begin n_fail++; $display("FAIL wr_rd_lane0: got %h want 5A", dq_out[7:0]); end
    nop();
    n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL wr_rd_late_oe: got %b want 00", dq_oe); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_rd_err: got %b want 0", err); end
    cmd(C_PRE, 2'd0, 13'h400, 2'd0, 16'd0);
  endtask

  task automatic test_random();
    int ba, row, col, ba2, row2;
    logic [1:0] m;
    logic [15:0] ex;
    for (int i = 0; i < 16; i++) begin
      ba  = int'($urandom_range(0, 3));
      row = int'($urandom_range(0, 8191));
      col = int'($urandom_range(0, 511));
      act(ba, row); nop();
      wr(ba, col, 1'b0, 2'b00, 16'($urandom));
      wr(ba, col, 1'b1, 2'($urandom), 16'($urandom));
      ba2  = int'($urandom_range(0, 3));
      row2 = (row % 8) + 8 * int'($urandom_range(0, 1023));
      m    = 2'($urandom);
      ex   = mem_m[maddr(ba, row, col)];
      act(ba2, row2); nop();
      rd(ba2, col, 1'b1, m);
      n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL rand_early_oe[%0d]: got %b want 00", i, dq_oe); end
      nop();
      n_checks++; if (dq_oe !== ~m || dq_out !== ex) begin n_fail++; $display("FAIL rand_data[%0d]: got %b/%h want %b/%h", i, dq_oe, dq_out, ~m, ex); end
    end
    nop();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    int r, c1, c2;
    int cols [3];
    logic [1:0]  msk [3];
    logic [15:0] ex [3];
    r  = int'($urandom_range(0, 8191));
    c1 = int'($urandom_range(0, 255));
    c2 = c1 + 256;
    act(1, r); nop();
    wr(1, c1, 1'b0, 2'b00, 16'($urandom));
    wr(1, c2, 1'b1, 2'b00, 16'($urandom));
    cols[0] = c1; cols[1] = c2; cols[2] = c1;
    for (int cl = 2; cl <= 3; cl++) begin
      cmd(C_MRS, 2'd0, 13'(cl << 4), 2'd0, 16'd0);
      for (int k = 0; k < 3; k++) begin
        msk[k] = 2'($urandom);
        ex[k]  = mem_m[maddr(1, r, cols[k])];
      end
      act(1, r); nop(); nop();
      for (int e = 1; e <= 6; e++) begin
        int j;
        if (e <= 3) rd(1, cols[e-1], (e == 3), msk[e-1]);
        else        nop();
        j = e - cl;
        if (j >= 0 && j <= 2) begin
          n_checks++; if (dq_oe !== ~msk[j] || dq_out !== ex[j]) begin n_fail++; $display("FAIL b2b_cl%0d_data[%0d]: got %b/%h want %b/%h", cl, j, dq_oe, dq_out, ~msk[j], ex[j]); end
        end else begin
          n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL b2b_cl%0d_idle_oe[e%0d]: got %b want 00", cl, e, dq_oe); end
        end
      end
    end
    cmd(C_MRS, 2'd0, 13'h020, 2'd0, 16'd0);
  endtask

  task automatic test_trcd_error();
    logic [15:0] d;
    d = 16'($urandom);
    act(0, 7); nop();
    wr(0, 9, 1'b1, 2'b00, d);
    act(0, 7);
    rd(0, 9, 1'b0, 2'b00);
    n_checks++; if (err !== CHK || err_code !== (CHK ? 3'd3 : 3'd0)) begin n_fail++; $display("FAIL trcd_err: got %b/%0d want %b/%0d", err, err_code, CHK, CHK ? 3 : 0); end
    nop();
    n_checks++; if (dq_oe !== 2'b11 || dq_out !== d) begin n_fail++; $display("FAIL trcd_data: got %b/%h want 11/%h", dq_oe, dq_out, d); end
    act(0, 7);
    n_checks++; if (err_code !== (CHK ? 3'd3 : 3'd0)) begin n_fail++; $display("FAIL trcd_sticky: got %0d want %0d", err_code, CHK ? 3 : 0); end
    cmd(C_PRE, 2'd0, 13'h400, 2'd0, 16'd0);
  endtask

  task automatic test_ref_error_reset();
    logic [15:0] d;
    d = 16'($urandom);
    pulse_reset();
    n_checks++; if (err !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL rst_clear_err: got %b/%0d want 0/0", err, err_code); end
    do_init(2);
    act(2, 100); nop(); nop();
    cmd(C_REF, 2'd0, 13'd0, 2'd0, 16'd0);
    n_checks++; if (err_code !== (CHK ? 3'd4 : 3'd0)) begin n_fail++; $display("FAIL ref_active_code: got %0d want %0d", err_code, CHK ? 4 : 0); end
    n_checks++; if (refresh_cnt !== 16'd3) begin n_fail++; $display("FAIL ref_count: got %0d want 3", refresh_cnt); end
    wr(2, 20, 1'b0, 2'b00, d);
    rd(2, 20, 1'b1, 2'b00);
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (dq_oe !== 2'b00 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset: got oe %b err %b want 00/0", dq_oe, err); end
    @(posedge clk); #1;
    resetn = 1'b1;
    nop();
    n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL reset_discard: got %b want 00", dq_oe); end
    do_init(2);
    act(2, 100); nop();
    rd(2, 20, 1'b1, 2'b00);
    nop();
    n_checks++; if (dq_oe !== 2'b11 || dq_out !== d) begin n_fail++; $display("FAIL ram_retained: got %b/%h want 11/%h", dq_oe, dq_out, d); end
  endtask

  task automatic test_priority_and_mrs();
    logic [15:0] d;
    int r;
    pulse_reset();
    rd(1, 0, 1'b0, 2'b00);
    n_checks++; if (err_code !== (CHK ? 3'd2 : 3'd0)) begin n_fail++; $display("FAIL lowest_code: got %0d want %0d", err_code, CHK ? 2 : 0); end
    pulse_reset();
    do_init(2);
    n_checks++; if (refresh_cnt !== 16'd2 || init_done !== 1'b1) begin n_fail++; $display("FAIL reinit: got %0d/%b want 2/1", refresh_cnt, init_done); end
    cmd(C_MRS, 2'd0, 13'h050, 2'd0, 16'd0);
    n_checks++; if (err_code !== (CHK ? 3'd5 : 3'd0)) begin n_fail++; $display("FAIL bad_cl_code: got %0d want %0d", err_code, CHK ? 5 : 0); end
    d = 16'($urandom);
    r = int'($urandom_range(0, 8191));
    act(3, r); nop();
    wr(3, 77, 1'b0, 2'b00, d);
    rd(3, 77, 1'b1, 2'b01);
    n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL bad_cl_early: got %b want 00", dq_oe); end
    nop();
    n_checks++; if (dq_oe !== 2'b10 || dq_out !== d) begin n_fail++; $display("FAIL bad_cl_keeps_cl2: got %b/%h want 10/%h", dq_oe, dq_out, d); end
    nop();
    n_checks++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL bad_cl_late: got %b want 00", dq_oe); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_random();
    test_back_to_back();
    test_trcd_error();
    test_ref_error_reset();
    test_priority_and_mrs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
